buffer_push_arbiter: RTL and testbench

//   Shares one buffer instance (memory_pointer + storage, FIFO or FILO) between NUM_REQ producers.

---
 rtl/buffer_push_arbiter.sv | 129 ++++++++++++
 tb/tb_buffer_push_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_push_arbiter.sv
// Round-robin push arbiter and pop forwarder for one shared FIFO/FILO buffer.
// Tracks occupancy so the buffer is never overfilled or underrun, and can drain it on a flush.
module buffer_push_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             pop_req,
    output logic                             pop_ack,
    input  logic                             flush,
    output logic                             buf_push,
    output logic                             buf_pop,
    output logic [DATA_WIDTH-1:0]            buf_wdata,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             full,
    output logic                             empty,
    output logic                             busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic RUN   = 1'b0;
    localparam logic FLUSH = 1'b1;

    logic                  state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         grant_id_q, grant_id_d;
    logic                  buf_push_q, buf_push_d;
    logic                  buf_pop_q, buf_pop_d;
    logic [DATA_WIDTH-1:0] buf_wdata_q, buf_wdata_d;

    logic                  found;
    logic [IW-1:0]         winner;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  in_run, flush_go, accept_ok, push_acc, pop_acc;

    function automatic int rr_idx(input int base, input int k);
        int s;
        s = base + k;
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    // First valid producer at or after rr_ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[rr_idx(int'(rr_ptr_q), k)]) begin
                found    = 1'b1;
                winner   = IW'(rr_idx(int'(rr_ptr_q), k));
                win_data = req_data[rr_idx(int'(rr_ptr_q), k)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A flush of an already-empty buffer is a no-op and does not block traffic.
    always_comb begin
        in_run    = (state_q == RUN);
        flush_go  = in_run && flush && !empty;
        accept_ok = in_run && !flush_go && !rst;
        push_acc  = accept_ok && found && !full;
        pop_acc   = accept_ok && pop_req && !empty;
        req_ready = '0;
        if (push_acc) req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        buf_push_d  = push_acc;
        buf_pop_d   = pop_acc;
        buf_wdata_d = push_acc ? win_data : buf_wdata_q;
        if (push_acc) begin
            grant_id_d = winner;
            rr_ptr_d   = (winner == IW'(NUM_REQ-1)) ? '0 : winner + IW'(1);
        end
        if (in_run) begin
            count_d = count_q + CW'(push_acc) - CW'(pop_acc);
            if (flush_go) state_d = FLUSH;
        end else if (!empty) begin
            buf_pop_d = 1'b1;
            count_d   = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = RUN;
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            count_q     <= '0;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            buf_push_q  <= 1'b0;
            buf_pop_q   <= 1'b0;
            buf_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            buf_push_q  <= buf_push_d;
            buf_pop_q   <= buf_pop_d;
            buf_wdata_q <= buf_wdata_d;
        end
    end

    assign pop_ack   = pop_acc;
    assign buf_push  = buf_push_q;
    assign buf_pop   = buf_pop_q;
    assign buf_wdata = buf_wdata_q;
    assign grant_id  = grant_id_q;
    assign count     = count_q;
    assign busy      = (state_q == FLUSH);
endmodule

// File: tb/tb_buffer_push_arbiter.sv
// Bench for buffer_push_arbiter: expected pushes go into a queue and are matched on buf_push.
module tb_buffer_push_arbiter;
    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int NR = 4;

    logic            clk, rst;
    logic [NR-1:0]   req_valid, req_ready;
    logic [NR*DW-1:0] req_data;
    logic            pop_req, pop_ack, flush;
    logic            buf_push, buf_pop;
    logic [DW-1:0]   buf_wdata;
    logic [1:0]      grant_id;
    logic [3:0]      count;
    logic            full, empty, busy;

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];
    logic [9:0] e;

    buffer_push_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .pop_req(pop_req), .pop_ack(pop_ack), .flush(flush),
        .buf_push(buf_push), .buf_pop(buf_pop), .buf_wdata(buf_wdata),
        .grant_id(grant_id), .count(count), .full(full), .empty(empty), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every registered push must match the oldest expected {grant, data}.
    always @(negedge clk) begin
        if (!rst && buf_push) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_push grant=%0d data=%h", grant_id, buf_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({grant_id, buf_wdata} !== e) begin
                    failures++;
                    $display("FAIL sb_push got grant=%0d data=%h exp grant=%0d data=%h",
                             grant_id, buf_wdata, e[9:8], e[7:0]);
                end
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_valid = '0;
        req_data  = '0;
        pop_req   = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        exp_q.delete();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        repeat (2) cyc();
        req_valid = 4'b1111;
        pop_req = 1'b1;
        #1;
        checks++;
        if ({req_ready, pop_ack, buf_push, buf_pop, buf_wdata, grant_id, count, busy, full, empty}
            !== {4'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state ready=%b ack=%b push=%b pop=%b wdata=%h gid=%0d cnt=%0d busy=%b full=%b empty=%b",
                     req_ready, pop_ack, buf_push, buf_pop, buf_wdata, grant_id, count, busy, full, empty);
        end
        // Release, accept from producer 2, then reset while buf_push is high.
        rst = 1'b0;
        idle_inputs();
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 8'h3C;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL reset_pre_grant ready=%b exp=0100", req_ready); end
        exp_q.push_back({2'd2, 8'h3C});
        cyc();
        checks++;
        if (buf_push !== 1'b1) begin failures++; $display("FAIL reset_pre_push push=%b exp=1", buf_push); end
        rst = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if ({buf_push, buf_pop, buf_wdata, grant_id, count, busy} !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid push=%b pop=%b wdata=%h gid=%0d cnt=%0d busy=%b exp all 0",
                     buf_push, buf_pop, buf_wdata, grant_id, count, busy);
        end
        exp_q.delete();
        cyc();
        rst = 1'b0;
        req_valid = 4'b1111;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_next_grant ready=%b exp=0001", req_ready); end
        exp_q.push_back({2'd0, 8'h11});
        cyc();
        idle_inputs();
        checks++;
        if (count !== 4'd1) begin failures++; $display("FAIL reset_count_after count=%0d exp=1", count); end
    endtask

    task automatic test_round_robin;
        logic [7:0] d;
        do_reset();
        for (int w = 0; w < 8; w++) begin
            req_valid = 4'b1111;
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'((i << 4) | w);
            #1;
            checks++;
            if (req_ready !== 4'(1 << (w % 4))) begin
                failures++;
                $display("FAIL rr_grant word=%0d ready=%b exp=%b", w, req_ready, 4'(1 << (w % 4)));
            end
            d = 8'(((w % 4) << 4) | w);
            exp_q.push_back({2'(w % 4), d});
            cyc();
        end
        checks++;
        if (count !== 4'd8 || full !== 1'b1) begin
            failures++;
            $display("FAIL rr_full count=%0d full=%b exp count=8 full=1", count, full);
        end
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL rr_ready_when_full ready=%b exp=0000", req_ready); end
        cyc();
        idle_inputs();
        checks++;
        if (buf_push !== 1'b0 || count !== 4'd8) begin
            failures++;
            $display("FAIL rr_no_push_when_full push=%b count=%0d exp push=0 count=8", buf_push, count);
        end
    endtask

    task automatic test_latency;
        do_reset();
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 8'hA5;
        #1;
        checks++;
        if (req_ready !== 4'b0100 || count !== 4'd0) begin
            failures++;
            $display("FAIL lat_cycle_n ready=%b count=%0d exp ready=0100 count=0", req_ready, count);
        end
        exp_q.push_back({2'd2, 8'hA5});
        cyc();
        idle_inputs();
        checks++;
        if (buf_push !== 1'b1 || buf_wdata !== 8'hA5 || count !== 4'd1) begin
            failures++;
            $display("FAIL lat_cycle_n1 push=%b wdata=%h count=%0d exp push=1 wdata=a5 count=1", buf_push, buf_wdata, count);
        end
        cyc();
        checks++;
        if (buf_push !== 1'b0 || buf_wdata !== 8'hA5 || count !== 4'd1) begin
            failures++;
            $display("FAIL lat_cycle_n2 push=%b wdata=%h count=%0d exp push=0 wdata=a5 count=1", buf_push, buf_wdata, count);
        end
    endtask

    task automatic test_full_pop;
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            req_valid = 4'b0001;
            req_data[0 +: DW] = 8'(8'h50 + k);
            exp_q.push_back({2'd0, 8'(8'h50 + k)});
            cyc();
        end
        req_valid = 4'b0010;
        req_data[DW +: DW] = 8'hB1;
        pop_req = 1'b1;
        #1;
        checks++;
        if (pop_ack !== 1'b1 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL full_both ack=%b ready=%b exp ack=1 ready=0000", pop_ack, req_ready);
        end
        cyc();
        pop_req = 1'b0;
        checks++;
        if (count !== 4'd7 || buf_pop !== 1'b1 || buf_push !== 1'b0) begin
            failures++;
            $display("FAIL full_after_pop count=%0d pop=%b push=%b exp 7/1/0", count, buf_pop, buf_push);
        end
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL full_retry_ready ready=%b exp=0010", req_ready); end
        exp_q.push_back({2'd1, 8'hB1});
        cyc();
        idle_inputs();
        checks++;
        if (count !== 4'd8 || buf_push !== 1'b1 || buf_pop !== 1'b0) begin
            failures++;
            $display("FAIL full_refill count=%0d push=%b pop=%b exp 8/1/0", count, buf_push, buf_pop);
        end
    endtask

    task automatic test_flush;
        int nb, np, first, last;
        nb = 0; np = 0; first = -1; last = -1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            req_valid = 4'b0001;
            req_data[0 +: DW] = 8'(8'h60 + k);
            exp_q.push_back({2'd0, 8'(8'h60 + k)});
            cyc();
        end
        checks++;
        if (count !== 4'd5) begin failures++; $display("FAIL flush_prefill count=%0d exp=5", count); end
        flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL flush_cycle_ready ready=%b exp=0000", req_ready); end
        cyc();
        flush = 1'b0;
        pop_req = 1'b1;
        for (int t = 0; t < 10; t++) begin
            if (busy) begin
                nb++;
                checks++;
                if (req_ready !== 4'b0000 || pop_ack !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_busy_handshake t=%0d ready=%b ack=%b exp 0000/0", t, req_ready, pop_ack);
                end
            end else begin
                req_valid = '0;
                pop_req = 1'b0;
            end
            if (buf_pop) begin
                np++;
                if (first < 0) first = t;
                last = t;
            end
            cyc();
        end
        idle_inputs();
        checks++;
        if (nb != 5) begin failures++; $display("FAIL flush_busy_cycles got=%0d exp=5", nb); end
        checks++;
        if (np != 5 || last - first != 4) begin
            failures++;
            $display("FAIL flush_pop_run pops=%0d span=%0d exp pops=5 span=4", np, last - first);
        end
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_end count=%0d empty=%b busy=%b exp 0/1/0", count, empty, busy);
        end
    endtask

    task automatic test_empty_pop;
        do_reset();
        pop_req = 1'b1;
        repeat (3) begin
            #1;
            checks++;
            if (pop_ack !== 1'b0) begin failures++; $display("FAIL empty_pop_ack ack=%b exp=0", pop_ack); end
            cyc();
            checks++;
            if (buf_pop !== 1'b0 || count !== 4'd0) begin
                failures++;
                $display("FAIL empty_pop_state pop=%b count=%0d exp 0/0", buf_pop, count);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_latency();
        test_full_pop();
        test_flush();
        test_empty_pop();
        cyc();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover entries=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
